// File: rtl/psum_ofifo_pkg.sv
// Shared sizing defaults for the partial-sum output FIFO and its column queues.
package psum_ofifo_pkg;

    localparam int unsigned COL_DEF     = 8;
    localparam int unsigned PSUM_BW_DEF = 16;
    localparam int unsigned DEPTH_DEF   = 16;
    localparam int unsigned PTR_W_DEF   = $clog2(DEPTH_DEF);

    // Pointer width for a queue of d entries; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-column partial-sum queue: storage, wrapping pointers and an occupancy count.
module ofifo_col
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW_DEF,
    parameter int unsigned depth   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [psum_bw-1:0] data_i,
    output logic [psum_bw-1:0] head_o,
    output logic               count_full_o,
    output logic               count_empty_o
);

    localparam int unsigned PTR_W = ptr_w(depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [psum_bw-1:0] mem_q [depth];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_ok_c;

    assign count_full_o  = (cnt_q == CNT_W'(depth));
    assign count_empty_o = (cnt_q == '0);
    assign head_o        = mem_q[rd_ptr_q];

    // A full column still takes data when the same edge frees a slot.
    assign push_ok_c = push_i & (~count_full_o | pop_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO that reassembles skewed per-column MAC results into whole rows.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned col     = COL_DEF,
    parameter int unsigned psum_bw = PSUM_BW_DEF,
    parameter int unsigned depth   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_ovf
);

    logic [col-1:0]         full_c;
    logic [col-1:0]         empty_c;
    logic [col-1:0]         drop_c;
    logic [psum_bw*col-1:0] head_c;
    logic                   pop_c;

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    for (genvar k = 0; k < col; k++) begin : g_col
        ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk           (clk),
            .rst_n         (reset),
            .push_i        (wr[k]),
            .pop_i         (pop_c),
            .data_i        (in[psum_bw*k +: psum_bw]),
            .head_o        (head_c[psum_bw*k +: psum_bw]),
            .count_full_o  (full_c[k]),
            .count_empty_o (empty_c[k])
        );
    end

    assign o_ready = ~|empty_c;
    assign o_full  = |full_c;
    assign pop_c   = rd & o_ready;
    assign drop_c  = wr & full_c & {col{~pop_c}};

    always_comb begin
        out_d   = out_q;
        valid_d = pop_c;
        ovf_d   = ovf_q | (|drop_c);
        if (pop_c) begin
            out_d = head_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out     = out_q;
    assign o_valid = valid_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: vector table, corner sequences, queue model and row scoreboard.
module tb_psum_ofifo;

    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = COL * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in;
    logic [COL-1:0] wr;
    logic          rd;
    logic [DW-1:0] out;
    logic          o_valid, o_ready, o_full, o_ovf;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] mq [COL][$];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_out;
    logic          exp_ovf;

    typedef struct {
        int           row;
        logic [7:0]   wr;
        logic         rd;
        logic         exp_ready;
        logic         exp_valid;
    } vec_t;

    vec_t vt [11];

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_full  (o_full),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] row_data(input int r);
        logic [DW-1:0] res;
        for (int k = 0; k < COL; k++) begin
            res[BW*k +: BW] = BW'(r * 256 + k + 1);
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_ready();
        for (int k = 0; k < COL; k++) begin
            if (mq[k].size() == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic model_full();
        for (int k = 0; k < COL; k++) begin
            if (mq[k].size() == DEPTH) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic [COL-1:0] w, input logic [DW-1:0] d, input logic r);
        logic          pop;
        logic          full_k;
        logic [DW-1:0] row;
        wr  = w;
        in  = d;
        rd  = r;
        pop = r & model_ready();
        row = exp_out;
        for (int k = 0; k < COL; k++) begin
            full_k = (mq[k].size() == DEPTH);
            if (pop) row[BW*k +: BW] = mq[k].pop_front();
            if (w[k]) begin
                if (!full_k || pop) mq[k].push_back(d[BW*k +: BW]);
                else exp_ovf = 1'b1;
            end
        end
        if (pop) begin
            sb.push_back(row);
            exp_out = row;
        end
        @(posedge clk);
        #1;
        chk("o_valid", DW'(o_valid), DW'(pop));
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", DW'(1), DW'(0));
            end else begin
                chk("sb_row", out, sb.pop_front());
            end
        end
        chk("out_hold", out, exp_out);
        chk("o_ready", DW'(o_ready), DW'(model_ready()));
        chk("o_full", DW'(o_full), DW'(model_full()));
        chk("o_ovf", DW'(o_ovf), DW'(exp_ovf));
    endtask

    task automatic model_clear();
        for (int k = 0; k < COL; k++) mq[k].delete();
        sb.delete();
        exp_out = '0;
        exp_ovf = 1'b0;
    endtask

    // Assert reset away from any edge, confirm the immediate clear, then release.
    task automatic do_reset();
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        in    = '0;
        model_clear();
        #1;
        chk("rst_ready", DW'(o_ready), DW'(0));
        chk("rst_full", DW'(o_full), DW'(0));
        chk("rst_valid", DW'(o_valid), DW'(0));
        chk("rst_ovf", DW'(o_ovf), DW'(0));
        chk("rst_out", out, DW'(0));
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        in    = '0;
        model_clear();
        #2;
        do_reset();

        // Single full row, then a pop; skewed fill with early reads ignored.
        vt[0] = '{0, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[1] = '{0, 8'h00, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < COL; k++) begin
            vt[2+k] = '{1, 8'(1 << k), 1'b1, (k == COL - 1), 1'b0};
        end
        vt[10] = '{1, 8'h00, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].wr, row_data(vt[i].row), vt[i].rd);
            chk("tbl_ready", DW'(o_ready), DW'(vt[i].exp_ready));
            chk("tbl_valid", DW'(o_valid), DW'(vt[i].exp_valid));
            if (i == 1) chk("tbl_row_1to8", out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
            if (i == 10) chk("tbl_skew_row", out, 128'h0108_0107_0106_0105_0104_0103_0102_0101);
        end

        // Overflow: 16 rows fill, the 17th is dropped, drain returns rows in order.
        for (int r = 0; r < DEPTH; r++) cycle('1, row_data(10 + r), 1'b0);
        chk("full_after16", DW'(o_full), DW'(1));
        chk("ovf_before17", DW'(o_ovf), DW'(0));
        cycle('1, row_data(99), 1'b0);
        chk("ovf_after17", DW'(o_ovf), DW'(1));
        for (int r = 0; r < DEPTH; r++) begin
            cycle('0, '0, 1'b1);
            chk("drain_row", out, row_data(10 + r));
        end
        chk("drained_ready", DW'(o_ready), DW'(0));
        chk("ovf_sticky", DW'(o_ovf), DW'(1));

        // Write and pop together on a full queue.
        do_reset();
        for (int r = 0; r < DEPTH; r++) cycle('1, row_data(20 + r), 1'b0);
        cycle('1, row_data(50), 1'b1);
        chk("wp_out", out, row_data(20));
        chk("wp_ovf", DW'(o_ovf), DW'(0));
        chk("wp_full", DW'(o_full), DW'(1));
        for (int r = 0; r < DEPTH; r++) cycle('0, '0, 1'b1);
        chk("wp_last_row", out, row_data(50));

        // Read on empty holds out; mid-stream reset clears without a clock edge.
        cycle('0, '0, 1'b1);
        chk("empty_rd_valid", DW'(o_valid), DW'(0));
        chk("empty_rd_out", out, row_data(50));
        for (int r = 0; r < 5; r++) cycle('1, row_data(60 + r), 1'b0);
        chk("pre_rst_ready", DW'(o_ready), DW'(1));
        do_reset();
        cycle('1, row_data(70), 1'b0);
        cycle('0, '0, 1'b1);
        chk("post_rst_row", out, row_data(70));
        cycle('0, '0, 1'b1);
        chk("post_rst_empty", DW'(o_ready), DW'(0));

        chk("sb_empty", DW'(sb.size()), DW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
